// File: rtl/core_v_xif_pkg.sv
// Minimal CORE-V eXtension interface types used by the Spatz configuration front end.
package core_v_xif_pkg;

  typedef struct packed {
    logic [31:0]      instr;
    logic [1:0][31:0] rs;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } x_result_t;

endpackage

// File: rtl/spatz_pkg.sv
// Spatz vector configuration constants, vtype layout and VLMAX helper.
package spatz_pkg;

  localparam int unsigned VLEN  = 512;
  localparam int unsigned ELEN  = 32;
  localparam int unsigned VLENB = VLEN / 8;

  typedef enum logic [2:0] {
    LMul1    = 3'b000,
    LMul2    = 3'b001,
    LMul4    = 3'b010,
    LMul8    = 3'b011,
    LMulRsvd = 3'b100,
    LMulF8   = 3'b101,
    LMulF4   = 3'b110,
    LMulF2   = 3'b111
  } vlmul_e;

  typedef enum logic [2:0] {
    Ew8  = 3'b000,
    Ew16 = 3'b001,
    Ew32 = 3'b010,
    Ew64 = 3'b011
  } vsew_e;

  typedef struct packed {
    logic        vill;
    logic [22:0] reserved;
    logic        vma;
    logic        vta;
    vsew_e       vsew;
    vlmul_e      vlmul;
  } vtype_t;

  localparam logic [31:0] VtypeVill = 32'h8000_0000;

  localparam logic [11:0] CsrVstart = 12'h008;
  localparam logic [11:0] CsrVl     = 12'hC20;
  localparam logic [11:0] CsrVtype  = 12'hC21;
  localparam logic [11:0] CsrVlenb  = 12'hC22;

  localparam logic [6:0] OpcodeV      = 7'h57;
  localparam logic [6:0] OpcodeSystem = 7'h73;
  localparam logic [2:0] F3Cfg        = 3'd7;

  // Returns VLMAX for a vtype, or 0 when the vtype is not supported.
  function automatic logic [31:0] vlmax(vtype_t vt);
    int   lmul_l2;
    int   sew_l2;
    logic legal;
    case (vt.vlmul)
      LMul1:   lmul_l2 = 0;
      LMul2:   lmul_l2 = 1;
      LMul4:   lmul_l2 = 2;
      LMul8:   lmul_l2 = 3;
      LMulF8:  lmul_l2 = -3;
      LMulF4:  lmul_l2 = -2;
      LMulF2:  lmul_l2 = -1;
      default: lmul_l2 = 0;
    endcase
    sew_l2 = 3 + int'(vt.vsew);
    legal  = !vt.vill && (vt.reserved == '0) && (vt.vlmul != LMulRsvd) &&
             (sew_l2 <= $clog2(ELEN)) && (lmul_l2 >= sew_l2 - $clog2(ELEN));
    return legal ? (32'd1 << ($clog2(VLEN) + lmul_l2 - sew_l2)) : 32'd0;
  endfunction

endpackage

// File: rtl/spatz_vcsr.sv
// Vector CSR state (vstart, vl, vtype) and vl computation for configuration instructions.
module spatz_vcsr
  import spatz_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_we_i,
  input  logic [31:0] cfg_vtype_i,
  input  logic [31:0] cfg_avl_i,
  input  logic        cfg_keep_vl_i,
  input  logic        vstart_we_i,
  input  logic [31:0] vstart_wdata_i,
  output logic [31:0] vstart_o,
  output logic [31:0] vl_o,
  output logic [31:0] vtype_o,
  output logic [31:0] cfg_vl_o
);

  logic [31:0] vstart_q, vstart_d;
  logic [31:0] vl_q, vl_d;
  vtype_t      vtype_q, vtype_d;
  logic [31:0] new_vlmax, old_vlmax;
  logic        cfg_ok;

  always_comb begin
    new_vlmax = vlmax(vtype_t'(cfg_vtype_i));
    old_vlmax = vlmax(vtype_q);
    // Keeping vl is only legal when VLMAX (i.e. the SEW/LMUL ratio) is unchanged.
    cfg_ok    = (new_vlmax != '0) && (!cfg_keep_vl_i || (old_vlmax == new_vlmax));
    if (!cfg_ok) begin
      cfg_vl_o = '0;
    end else if (cfg_keep_vl_i) begin
      cfg_vl_o = vl_q;
    end else begin
      cfg_vl_o = (cfg_avl_i < new_vlmax) ? cfg_avl_i : new_vlmax;
    end

    vstart_d = vstart_q;
    vl_d     = vl_q;
    vtype_d  = vtype_q;
    if (cfg_we_i) begin
      vstart_d = '0;
      vl_d     = cfg_vl_o;
      vtype_d  = cfg_ok ? vtype_t'(cfg_vtype_i) : vtype_t'(VtypeVill);
    end else if (vstart_we_i) begin
      vstart_d = vstart_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vstart_q <= '0;
      vl_q     <= '0;
      vtype_q  <= vtype_t'(VtypeVill);
    end else begin
      vstart_q <= vstart_d;
      vl_q     <= vl_d;
      vtype_q  <= vtype_d;
    end
  end

  assign vstart_o = vstart_q;
  assign vl_o     = vl_q;
  assign vtype_o  = vtype_q;

endmodule

// File: rtl/spatz_top.sv
// Spatz configuration front end: X-interface decode of vset{i}vl{i} and vector CSR accesses.
// Optional feature macro: SPATZ_VSETIVLI_EN enables decoding of vsetivli.
module spatz_top
  import spatz_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          x_issue_valid_i,
  output logic                          x_issue_ready_o,
  input  core_v_xif_pkg::x_issue_req_t  x_issue_req_i,
  output core_v_xif_pkg::x_issue_resp_t x_issue_resp_o,
  output logic                          x_result_valid_o,
  input  logic                          x_result_ready_i,
  output core_v_xif_pkg::x_result_t     x_result_o
);

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1;
  logic [11:0] csr_addr;
  logic        cfg_space, is_vsetvli, is_vsetivli, is_vsetvl, is_cfg, is_csr, accept, fire;
  logic [31:0] cfg_vtype, cfg_avl, cfg_vl, csr_rdata, csr_operand, vstart_wdata;
  logic        cfg_keep_vl, vstart_we;
  logic [31:0] vstart, vl, vtype;

  assign instr    = x_issue_req_i.instr;
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd       = instr[11:7];
  assign rs1      = instr[19:15];
  assign csr_addr = instr[31:20];

  always_comb begin
    cfg_space  = (opcode == OpcodeV) && (funct3 == F3Cfg);
    is_vsetvli = cfg_space && !instr[31];
    is_vsetvl  = cfg_space && (instr[31:25] == 7'b1000000);
`ifdef SPATZ_VSETIVLI_EN
    is_vsetivli = cfg_space && (instr[31:30] == 2'b11);
`else
    is_vsetivli = 1'b0;
`endif
    is_cfg = is_vsetvli || is_vsetivli || is_vsetvl;

    cfg_vtype   = x_issue_req_i.rs[1];
    cfg_avl     = x_issue_req_i.rs[0];
    cfg_keep_vl = 1'b0;
    if (is_vsetvli) begin
      cfg_vtype = {21'b0, instr[30:20]};
    end else if (is_vsetivli) begin
      cfg_vtype = {22'b0, instr[29:20]};
    end
    if (is_vsetivli) begin
      cfg_avl = {27'b0, rs1};
    end else if (rs1 == 5'd0) begin
      cfg_avl     = '1;
      cfg_keep_vl = (rd == 5'd0);
    end

    csr_rdata = '0;
    is_csr    = 1'b0;
    if ((opcode == OpcodeSystem) && (funct3 != 3'd0) && (funct3 != 3'd4)) begin
      is_csr = 1'b1;
      case (csr_addr)
        CsrVstart: csr_rdata = vstart;
        CsrVl:     csr_rdata = vl;
        CsrVtype:  csr_rdata = vtype;
        CsrVlenb:  csr_rdata = VLENB;
        default:   is_csr = 1'b0;
      endcase
    end

    csr_operand = funct3[2] ? {27'b0, rs1} : x_issue_req_i.rs[0];
    case (funct3[1:0])
      2'b01:   vstart_wdata = csr_operand;
      2'b10:   vstart_wdata = vstart | csr_operand;
      default: vstart_wdata = vstart & ~csr_operand;
    endcase

    accept    = is_cfg || is_csr;
    fire      = x_issue_valid_i && x_issue_ready_o && accept;
    vstart_we = fire && is_csr && (csr_addr == CsrVstart);

    x_issue_resp_o.accept    = accept;
    x_issue_resp_o.writeback = accept && (rd != 5'd0);
    x_issue_resp_o.exc       = !accept;

    x_result_valid_o = x_issue_valid_i && accept && !rst_i;
    x_result_o.data  = is_cfg ? cfg_vl : csr_rdata;
    x_result_o.rd    = rd;
    x_result_o.we    = accept && (rd != 5'd0);
  end

  assign x_issue_ready_o = x_result_ready_i;

  spatz_vcsr u_vcsr (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_we_i       (fire && is_cfg),
    .cfg_vtype_i    (cfg_vtype),
    .cfg_avl_i      (cfg_avl),
    .cfg_keep_vl_i  (cfg_keep_vl),
    .vstart_we_i    (vstart_we),
    .vstart_wdata_i (vstart_wdata),
    .vstart_o       (vstart),
    .vl_o           (vl),
    .vtype_o        (vtype),
    .cfg_vl_o       (cfg_vl)
  );

endmodule

// File: tb/tb_spatz_top.sv
// Directed self-checking bench for spatz_top with hand-computed expectations.
module tb_spatz_top;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          x_issue_valid;
  logic                          x_issue_ready;
  core_v_xif_pkg::x_issue_req_t  x_issue_req;
  core_v_xif_pkg::x_issue_resp_t x_issue_resp;
  logic                          x_result_valid;
  logic                          x_result_ready;
  core_v_xif_pkg::x_result_t     x_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spatz_top dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .x_issue_valid_i  (x_issue_valid),
    .x_issue_ready_o  (x_issue_ready),
    .x_issue_req_i    (x_issue_req),
    .x_issue_resp_o   (x_issue_resp),
    .x_result_valid_o (x_result_valid),
    .x_result_ready_i (x_result_ready),
    .x_result_o       (x_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] rs0, input logic [31:0] rs1);
    x_issue_valid     = 1'b1;
    x_issue_req.instr = instr;
    x_issue_req.rs[0] = rs0;
    x_issue_req.rs[1] = rs1;
  endtask

  // Issue one instruction, check the zero-latency response, then let it commit.
  task automatic op(input string tag, input logic [31:0] instr, input logic [31:0] rs0,
                    input logic [31:0] rs1, input logic exp_acc, input logic [31:0] exp_data);
    drive(instr, rs0, rs1);
    @(negedge clk);
    chk({tag, ".accept"}, {31'b0, x_issue_resp.accept}, {31'b0, exp_acc});
    chk({tag, ".exc"}, {31'b0, x_issue_resp.exc}, {31'b0, !exp_acc});
    chk({tag, ".valid"}, {31'b0, x_result_valid}, {31'b0, exp_acc});
    if (exp_acc) begin
      chk({tag, ".data"}, x_result.data, exp_data);
      chk({tag, ".wb"}, {31'b0, x_issue_resp.writeback}, {31'b0, instr[11:7] != 5'd0});
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] RdVl     = 32'hC201_2173;
  localparam logic [31:0] RdVtype  = 32'hC211_2173;
  localparam logic [31:0] RdVlenb  = 32'hC221_2173;
  localparam logic [31:0] RdVstart = 32'h0081_2173;

  initial begin
    rst            = 1'b1;
    x_result_ready = 1'b1;
    x_issue_valid  = 1'b0;
    x_issue_req    = '0;

    drive(RdVl, 32'd0, 32'd0);
    #12;
    chk("reset.valid", {31'b0, x_result_valid}, 32'd0);
    x_issue_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op("rst.vtype", RdVtype, 0, 0, 1'b1, 32'h8000_0000);
    op("rst.vl", RdVl, 0, 0, 1'b1, 32'd0);
    op("rst.vstart", RdVstart, 0, 0, 1'b1, 32'd0);

    op("vsetvli.e8m2", 32'h0015_7557, 32'd256, 0, 1'b1, 32'd128);
    op("rd.vl1", RdVl, 0, 0, 1'b1, 32'd128);
    op("keep.ratio_chg", 32'h0090_7057, 0, 0, 1'b1, 32'd0);
    op("rd.vtype_vill", RdVtype, 0, 0, 1'b1, 32'h8000_0000);
    op("rd.vl_vill", RdVl, 0, 0, 1'b1, 32'd0);
    op("vsetvli.e8m4_max", 32'h0820_7557, 0, 0, 1'b1, 32'd256);
    op("keep.e16m8", 32'h00B0_7057, 0, 0, 1'b1, 32'd256);
    op("rd.vtype_0b", RdVtype, 0, 0, 1'b1, 32'h0000_000B);
    op("rd.vlenb", RdVlenb, 0, 0, 1'b1, 32'd64);

    op("vstart.rsi6", 32'h0083_6173, 0, 0, 1'b1, 32'd0);
    op("vstart.rw4", 32'h0081_1173, 32'd4, 0, 1'b1, 32'd6);
    op("vstart.rs0", RdVstart, 0, 0, 1'b1, 32'd4);

    op("bad.opcode", 32'h0081_2174, 0, 0, 1'b0, 32'd0);
    op("vstart.kept", RdVstart, 0, 0, 1'b1, 32'd4);
    op("bad.csr", 32'hC231_2173, 0, 0, 1'b0, 32'd0);
    op("ro.vl_write", 32'hC201_1173, 32'd99, 0, 1'b1, 32'd256);
    op("ro.vl_after", RdVl, 0, 0, 1'b1, 32'd256);

    op("vsetvl.e32m4", 32'h80B5_7557, 32'd1000, 32'h0000_0012, 1'b1, 32'd64);
    op("cfg.clr_vstart", RdVstart, 0, 0, 1'b1, 32'd0);
    op("vsetvl.e64", 32'h80B5_7557, 32'd8, 32'h0000_0018, 1'b1, 32'd0);
    op("rd.vtype_e64", RdVtype, 0, 0, 1'b1, 32'h8000_0000);

    op("vsetvli.mf4", 32'h0065_7557, 32'd100, 0, 1'b1, 32'd16);
    op("vsetvli.mf8", 32'h0055_7557, 32'd100, 0, 1'b1, 32'd0);
    op("vsetvli.mf2_avl3", 32'h0075_7557, 32'd3, 0, 1'b1, 32'd3);
`ifdef SPATZ_VSETIVLI_EN
    op("vsetivli", 32'hC002_F557, 0, 0, 1'b1, 32'd5);
    op("rd.vl_ivli", RdVl, 0, 0, 1'b1, 32'd5);
`else
    op("vsetivli.off", 32'hC002_F557, 0, 0, 1'b0, 32'd0);
    op("rd.vl_ivli", RdVl, 0, 0, 1'b1, 32'd3);
`endif
    op("zimm.upper", 32'h4005_7557, 32'd5, 0, 1'b1, 32'd0);

    op("stall.pre", 32'h0083_6173, 0, 0, 1'b1, 32'd0);
    x_result_ready = 1'b0;
    drive(32'h0084_D173, 0, 0);
    #1;
    chk("stall.ready", {31'b0, x_issue_ready}, 32'd0);
    @(posedge clk);
    #1;
    x_result_ready = 1'b1;
    op("stall.no_commit", RdVstart, 0, 0, 1'b1, 32'd6);

    op("pre_rst.cfg", 32'h0015_7557, 32'd256, 0, 1'b1, 32'd128);
    drive(RdVl, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.valid", {31'b0, x_result_valid}, 32'd0);
    x_issue_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    op("midrst.vl", RdVl, 0, 0, 1'b1, 32'd0);
    op("midrst.vtype", RdVtype, 0, 0, 1'b1, 32'h8000_0000);
    x_issue_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
